fifo_dispatch: RTL

- Timed read-side sequencer for the shared fifo (B=160, N=16) in the signal generator.
- Pops one entry at a time and holds it until a free-running time counter reaches the entry's timestamp.
- Then issues the payload as a one-cycle strobe to the downstream generator.
- Flags and counts entries that arrive after their timestamp has passed.

---
 rtl/fifo_dispatch.sv | 62 ++++++
 1 files changed

// File: rtl/fifo_dispatch.sv
// fifo_dispatch: pops timestamped fifo entries and issues each payload when the time counter reaches its timestamp.
module fifo_dispatch #(
  parameter int B  = 160,
  parameter int TW = 32,
  parameter int LW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            fifo_empty,
  input  logic [B-1:0]    fifo_dout,
  output logic            fifo_rd_en,
  output logic [B-TW-1:0] dout,
  output logic            dout_valid,
  output logic            late,
  output logic [LW-1:0]   late_cnt,
  output logic [TW-1:0]   t_cnt,
  output logic            running
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;
  logic [1:0]      state, state_nx;
  logic [TW-1:0]   ts, d;
  logic [B-TW-1:0] pay;
  logic            issue;
  assign running    = state != IDLE;
  assign fifo_rd_en = state == FETCH && !fifo_empty;
  assign d          = ts - t_cnt;
  // a start in HOLD defers the decision so the entry is judged against the restarted counter
  assign issue      = state == HOLD && !start && !stop && (d == '0 || d[TW-1]);
  always_comb begin
    state_nx = stop            ? IDLE :
               state == IDLE   ? (start ? FETCH : IDLE) :
               state == FETCH  ? (fifo_rd_en ? WAIT : FETCH) :
               state == WAIT   ? HOLD :
               issue           ? FETCH : HOLD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ts         <= '0;
      pay        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      late       <= 1'b0;
      late_cnt   <= '0;
      t_cnt      <= '0;
    end else begin
      state      <= state_nx;
      t_cnt      <= (stop || start || state == IDLE) ? '0 : t_cnt + 1'b1;
      if (state == WAIT) {pay, ts} <= fifo_dout;
      if (issue) dout <= pay;
      dout_valid <= issue;
      late       <= issue && d[TW-1];
      late_cnt   <= (start && !stop) ? '0 :
                    (issue && d[TW-1] && ~&late_cnt) ? late_cnt + 1'b1 : late_cnt;
    end
  end
endmodule
